// File: rtl/memory_init_sequencer.sv
// memory_init_sequencer
//   Sweeps a target RAM with a constant value after reset, and again whenever
//   a flush is requested while the memory is ready. The write port is meant to
//   feed the target memory's write port directly. initDone tells the pipeline
//   that the memory contents are valid.
//
// Ports
//   clk         in   single clock, posedge
//   rst         in   synchronous active-high reset (from the reset sequencer)
//   flushReq    in   level request to re-run the sweep (only honoured in Ready)
//   writeReady  in   target memory accepts the write this cycle
//   writeValid  out  write request, high exactly while clearing
//   writeIndex  out  entry being written (the index counter register)
//   writeData   out  constant InitValue
//   initDone    out  high exactly while Ready
//   flushDone   out  one-cycle pulse in the first Ready cycle after a sweep
module memory_init_sequencer #(
    parameter int                   EntryCount = 64,
    parameter int                   DataWidth  = 32,
    parameter logic [DataWidth-1:0] InitValue  = '0,
    localparam int                  IndexWidth = (EntryCount > 1) ? $clog2(EntryCount) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flushReq,
    input  logic                  writeReady,
    output logic                  writeValid,
    output logic [IndexWidth-1:0] writeIndex,
    output logic [DataWidth-1:0]  writeData,
    output logic                  initDone,
    output logic                  flushDone
);

    typedef enum logic [1:0] {
        ST_RESET    = 2'd0,
        ST_CLEARING = 2'd1,
        ST_READY    = 2'd2
    } state_t;

    localparam logic [IndexWidth-1:0] LAST_INDEX = IndexWidth'(EntryCount - 1);

    state_t                state;
    logic [IndexWidth-1:0] index;
    logic                  flush_done;
    logic                  fire;

    // A write is accepted only while clearing and the memory is ready.
    assign fire = (state == ST_CLEARING) && writeReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RESET;
            index      <= '0;
            flush_done <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    state <= ST_CLEARING;
                end
                ST_CLEARING: begin
                    if (fire) begin
                        // Wrap at EntryCount-1 so out-of-range entries are
                        // never presented for non-power-of-two sizes.
                        if (index == LAST_INDEX) begin
                            index      <= '0;
                            state      <= ST_READY;
                            flush_done <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    // Clearing here every Ready cycle makes flushDone a pulse
                    // in the first Ready cycle, even if a flush starts then.
                    flush_done <= 1'b0;
                    if (flushReq) begin
                        state <= ST_CLEARING;
                        index <= '0;
                    end
                end
                default: begin
                    state      <= ST_RESET;
                    index      <= '0;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

    assign writeValid = (state == ST_CLEARING);
    assign initDone   = (state == ST_READY);
    assign writeIndex = index;
    assign writeData  = InitValue;
    assign flushDone  = flush_done;

endmodule

// File: tb/tb_memory_init_sequencer.sv
// tb_memory_init_sequencer
//   Three instances (EntryCount 8, 5 and 1) run in lockstep on shared stimulus.
//   Each is compared every cycle against a sweep-level model that tracks how
//   many writes the current sweep has accepted, plus directed end-of-phase
//   checks (write counts, per-index acceptance counts).
module tb_memory_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic fr  = 1'b0;
    logic wr  = 1'b1;

    logic        wv0, wv1, wv2;
    logic [2:0]  wi0;
    logic [2:0]  wi1;
    logic [0:0]  wi2;
    logic [31:0] wd0;
    logic [7:0]  wd1;
    logic [15:0] wd2;
    logic        id0, id1, id2;
    logic        fd0, fd1, fd2;

    memory_init_sequencer #(.EntryCount(8), .DataWidth(32), .InitValue(32'hDEADBEEF)) dut0 (
        .clk(clk), .rst(rst), .flushReq(fr), .writeReady(wr),
        .writeValid(wv0), .writeIndex(wi0), .writeData(wd0), .initDone(id0), .flushDone(fd0));
    memory_init_sequencer #(.EntryCount(5), .DataWidth(8), .InitValue(8'h5A)) dut1 (
        .clk(clk), .rst(rst), .flushReq(fr), .writeReady(wr),
        .writeValid(wv1), .writeIndex(wi1), .writeData(wd1), .initDone(id1), .flushDone(fd1));
    memory_init_sequencer #(.EntryCount(1), .DataWidth(16), .InitValue(16'h1234)) dut2 (
        .clk(clk), .rst(rst), .flushReq(fr), .writeReady(wr),
        .writeValid(wv2), .writeIndex(wi2), .writeData(wd2), .initDone(id2), .flushDone(fd2));

    logic        wv[3];
    logic        idn[3];
    logic        fdn[3];
    logic [31:0] widx[3];
    logic [31:0] wdat[3];
    assign wv[0] = wv0;  assign wv[1] = wv1;  assign wv[2] = wv2;
    assign idn[0] = id0; assign idn[1] = id1; assign idn[2] = id2;
    assign fdn[0] = fd0; assign fdn[1] = fd1; assign fdn[2] = fd2;
    assign widx[0] = 32'(wi0); assign widx[1] = 32'(wi1); assign widx[2] = 32'(wi2);
    assign wdat[0] = wd0;      assign wdat[1] = 32'(wd1); assign wdat[2] = 32'(wd2);

    // Reference model: a sweep is "busy" with cnt writes accepted so far;
    // the expected presented index is simply that count.
    int          n_ent[3] = '{8, 5, 1};
    logic [31:0] init_v[3] = '{32'hDEADBEEF, 32'h0000005A, 32'h00001234};
    bit          m_busy[3];
    bit          m_rdy[3];
    bit          m_pulse[3];
    int          m_cnt[3];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_busy[k] = 0; m_rdy[k] = 0; m_cnt[k] = 0; m_pulse[k] = 0;
            end else if (m_busy[k]) begin
                if (wr) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == n_ent[k]) begin
                        m_cnt[k] = 0; m_busy[k] = 0; m_rdy[k] = 1; m_pulse[k] = 1;
                    end
                end
            end else if (m_rdy[k]) begin
                m_pulse[k] = 0;
                if (fr) begin
                    m_rdy[k] = 0; m_busy[k] = 1; m_cnt[k] = 0;
                end
            end else begin
                m_busy[k] = 1;  // leaving reset
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("writeValid[%0d]", k), 32'(wv[k]), 32'(m_busy[k]));
            chk($sformatf("initDone[%0d]", k), 32'(idn[k]), 32'(m_rdy[k]));
            chk($sformatf("flushDone[%0d]", k), 32'(fdn[k]), 32'(m_pulse[k]));
            chk($sformatf("writeIndex[%0d]", k), widx[k], 32'(m_cnt[k]));
            chk($sformatf("writeData[%0d]", k), wdat[k], init_v[k]);
            chk($sformatf("no_overlap[%0d]", k), 32'(wv[k] & idn[k]), 32'd0);
        end
    endtask

    int vcnt;
    int acc[8];

    task automatic clear_stats();
        vcnt = 0;
        for (int i = 0; i < 8; i++) acc[i] = 0;
    endtask

    // Count dut0 write cycles and accepted indices for the coming edge.
    task automatic note_and_tick();
        if (wv[0]) begin
            vcnt++;
            if (wr) acc[widx[0]]++;
        end
        tick();
    endtask

    int st2, st5;

    initial begin
        // Reset and sweep
        rst = 1'b1; fr = 1'b0; wr = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        clear_stats();
        for (int c = 0; c < 10; c++) note_and_tick();
        chk("sweep_write_cycles", 32'(vcnt), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("sweep_acc_%0d", i), 32'(acc[i]), 32'd1);

        // Backpressure: stall twice on index 2 and once on index 5
        fr = 1'b1; tick(); fr = 1'b0;
        clear_stats(); st2 = 0; st5 = 0;
        for (int c = 0; c < 14; c++) begin
            wr = 1'b1;
            if (wv[0] && widx[0] == 2 && st2 < 2) begin wr = 1'b0; st2++; end
            if (wv[0] && widx[0] == 5 && st5 < 1) begin wr = 1'b0; st5++; end
            note_and_tick();
        end
        wr = 1'b1;
        chk("bp_write_cycles", 32'(vcnt), 32'd11);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_acc_%0d", i), 32'(acc[i]), 32'd1);

        // Flush, with a second request raised mid-sweep
        fr = 1'b1; tick(); fr = 1'b0;
        chk("flush_first_index", widx[0], 32'd0);
        tick(); tick();
        fr = 1'b1; tick(); tick(); fr = 1'b0;
        repeat (8) tick();
        chk("flush_no_resweep", 32'(idn[0]), 32'd1);

        // Reset while presenting index 4
        fr = 1'b1; tick(); fr = 1'b0;
        for (int c = 0; c < 8 && !(wv[0] && widx[0] == 4); c++) tick();
        chk("at_index4", widx[0], 32'd4);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_wv", 32'(wv[0]), 32'd0);
        chk("midrst_idx", widx[0], 32'd0);
        clear_stats();
        for (int c = 0; c < 12; c++) note_and_tick();
        chk("midrst_write_cycles", 32'(vcnt), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("midrst_acc_%0d", i), 32'(acc[i]), 32'd1);

        // Priority: rst and flushReq together in Ready
        rst = 1'b1; fr = 1'b1; tick();
        chk("prio_initDone", 32'(id0), 32'd0);
        chk("prio_flushDone", 32'(fd0), 32'd0);
        chk("prio_wv", 32'(wv0), 32'd0);
        rst = 1'b0; fr = 1'b0; tick();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 24) == 0);
            fr  = ($urandom_range(0, 7) == 0);
            wr  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
